// File: rtl/pac_move_ctrl.sv
// pac_move_ctrl: Pac-Man movement controller.
// Latches the player's direction request, then on each movement tick probes the
// wall-collision checker (requested direction first, current direction as a
// fallback) and steps the sprite when the path is clear.
// Optional build macro PAC_TUNNEL_WRAP_EN: horizontal moves wrap across the
// screen edge instead of clamping.
module pac_move_ctrl #(
  parameter int START_X = 304,
  parameter int START_Y = 352,
  parameter int STEP    = 2,
  parameter int SETTLE  = 3,
  parameter int X_MAX   = 608,
  parameter int Y_MAX   = 448
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       key_valid,
  input  logic [1:0] key_dir,
  input  logic       can_move,
  output logic [1:0] probe_dir,
  output logic [9:0] pac_x,
  output logic [8:0] pac_y,
  output logic [1:0] pac_dir,
  output logic       moving,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, PROBE_REQ, PROBE_CUR} state_e;
  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  localparam int             CW       = $clog2(SETTLE);
  localparam logic [CW-1:0]  CNT_LAST = CW'(SETTLE - 1);
  localparam logic [10:0]    STEP_W   = 11'(STEP);
  localparam logic [10:0]    XMAX_W   = 11'(X_MAX);
  localparam logic [10:0]    YMAX_W   = 11'(Y_MAX);
  localparam logic [9:0]     XMAX_X   = 10'(X_MAX);
  localparam logic [8:0]     YMAX_Y   = 9'(Y_MAX);

  state_e        state, next_state;
  logic [1:0]    pend;
  logic [1:0]    req;
  logic [CW-1:0] cnt;
  logic          settled;
  logic [1:0]    mv_dir;
  logic [10:0]   x_ext, y_ext;
  logic [9:0]    nx;
  logic [8:0]    ny;

  assign settled = (cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state logic: a clear requested path or a blocked straight-ahead
  // request finishes after one probe; a blocked turn falls back to a second probe
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (tick) next_state = PROBE_REQ;
      PROBE_REQ: if (settled) begin
                   if (can_move || (req == pac_dir)) next_state = IDLE;
                   else                               next_state = PROBE_CUR;
                 end
      PROBE_CUR: if (settled) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Output logic: busy whenever an evaluation is underway
  always_comb begin
    busy = (state != IDLE);
  end

  // Candidate position for the direction currently under test, full-width math
  always_comb begin
    mv_dir = (state == PROBE_REQ) ? req : pac_dir;
    x_ext  = {1'b0, pac_x};
    y_ext  = {2'b00, pac_y};
    nx     = pac_x;
    ny     = pac_y;
    case (mv_dir)
      DIR_UP:    ny = (y_ext >= STEP_W) ? 9'(y_ext - STEP_W) : '0;
      DIR_DOWN:  ny = ((y_ext + STEP_W) <= YMAX_W) ? 9'(y_ext + STEP_W) : YMAX_Y;
`ifdef PAC_TUNNEL_WRAP_EN
      DIR_LEFT:  nx = (x_ext < STEP_W) ? XMAX_X : 10'(x_ext - STEP_W);
      DIR_RIGHT: nx = ((x_ext + STEP_W) > XMAX_W) ? '0 : 10'(x_ext + STEP_W);
`else
      DIR_LEFT:  nx = (x_ext >= STEP_W) ? 10'(x_ext - STEP_W) : '0;
      DIR_RIGHT: nx = ((x_ext + STEP_W) <= XMAX_W) ? 10'(x_ext + STEP_W) : XMAX_X;
`endif
      default:   ;
    endcase
  end

  // Datapath: pending key, probe direction, settle counter, position/facing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend      <= DIR_LEFT;
      req       <= DIR_LEFT;
      probe_dir <= DIR_LEFT;
      pac_dir   <= DIR_LEFT;
      pac_x     <= 10'(START_X);
      pac_y     <= 9'(START_Y);
      moving    <= 1'b0;
      cnt       <= '0;
    end else begin
      if (key_valid) pend <= key_dir;
      case (state)
        IDLE: begin
          if (tick) begin
            // A key arriving on the tick cycle wins over the stored request
            req       <= key_valid ? key_dir : pend;
            probe_dir <= key_valid ? key_dir : pend;
            cnt       <= '0;
          end
        end
        PROBE_REQ: begin
          if (settled) begin
            cnt <= '0;
            if (can_move) begin
              pac_dir <= req;
              pac_x   <= nx;
              pac_y   <= ny;
              moving  <= 1'b1;
            end else if (req == pac_dir) begin
              moving <= 1'b0;
            end else begin
              probe_dir <= pac_dir;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PROBE_CUR: begin
          if (settled) begin
            cnt <= '0;
            if (can_move) begin
              pac_x  <= nx;
              pac_y  <= ny;
              moving <= 1'b1;
            end else begin
              moving <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pac_move_ctrl.sv
// Testbench for pac_move_ctrl: table-driven scenarios, hand sequences for
// ignored ticks and mid-evaluation reset, then randomized transactions checked
// against a behavioural model. Two instances run in lockstep; the second starts
// next to the screen edges to exercise clamping/wrapping.
module tb_pac_move_ctrl;

  localparam int STEP   = 2;
  localparam int SETTLE = 3;
  localparam int X_MAX  = 608;
  localparam int Y_MAX  = 448;
`ifdef PAC_TUNNEL_WRAP_EN
  localparam int XL = 608;
  localparam int XR = 0;
`else
  localparam int XL = 0;
  localparam int XR = 2;
`endif

  logic       clk = 1'b0;
  logic       rst, tick, key_valid, can_move;
  logic [1:0] key_dir;
  logic [1:0] probe_a, dir_a, probe_b, dir_b;
  logic [9:0] x_a, x_b;
  logic [8:0] y_a, y_b;
  logic       mov_a, busy_a, mov_b, busy_b;

  always #5 clk = ~clk;

  pac_move_ctrl dut_a (
    .clk(clk), .rst(rst), .tick(tick), .key_valid(key_valid), .key_dir(key_dir),
    .can_move(can_move), .probe_dir(probe_a), .pac_x(x_a), .pac_y(y_a),
    .pac_dir(dir_a), .moving(mov_a), .busy(busy_a)
  );

  pac_move_ctrl #(.START_X(1), .START_Y(447)) dut_b (
    .clk(clk), .rst(rst), .tick(tick), .key_valid(key_valid), .key_dir(key_dir),
    .can_move(can_move), .probe_dir(probe_b), .pac_x(x_b), .pac_y(y_b),
    .pac_dir(dir_b), .moving(mov_b), .busy(busy_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  int         mx [2];
  int         my [2];
  logic [1:0] mdir, mpend;
  bit         mmov;
  bit         cm_seq [0:2*SETTLE];

  typedef struct {
    bit         kv;
    logic [1:0] kd;
    bit         c1;
    bit         c2;
    int         tick_at;
    int         ax, ay;
    logic [1:0] adir;
    bit         amov;
    int         bx, by;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mx[0] = 304; my[0] = 352;
    mx[1] = 1;   my[1] = 447;
    mdir = 2'd2; mpend = 2'd2; mmov = 1'b0;
  endtask

  // One step in direction d for instance i, straight from the movement rules
  function automatic void model_move(input int i, input logic [1:0] d);
    int x, y;
    x = mx[i]; y = my[i];
    case (d)
      2'd0: y = (y - STEP < 0) ? 0 : y - STEP;
      2'd1: y = (y + STEP > Y_MAX) ? Y_MAX : y + STEP;
`ifdef PAC_TUNNEL_WRAP_EN
      2'd2: x = (x - STEP < 0) ? X_MAX : x - STEP;
      2'd3: x = (x + STEP > X_MAX) ? 0 : x + STEP;
`else
      2'd2: x = (x - STEP < 0) ? 0 : x - STEP;
      2'd3: x = (x + STEP > X_MAX) ? X_MAX : x + STEP;
`endif
      default: ;
    endcase
    mx[i] = x; my[i] = y;
  endfunction

  task automatic chk_model(input string tag);
    chk({tag, "_xa"}, int'(x_a), mx[0]);
    chk({tag, "_ya"}, int'(y_a), my[0]);
    chk({tag, "_xb"}, int'(x_b), mx[1]);
    chk({tag, "_yb"}, int'(y_b), my[1]);
    chk({tag, "_dir"}, int'(dir_a), int'(mdir));
    chk({tag, "_dirb"}, int'(dir_b), int'(mdir));
    chk({tag, "_mov"}, int'(mov_a), int'(mmov));
  endtask

  // One evaluation: tick with optional key, can_move per cycle from cm_seq.
  // Entered and left at #1 after a clock edge with the DUT idle.
  task automatic txn(input bit kv, input logic [1:0] kd, input bit noise, input int tick_at);
    logic [1:0] req, old_dir;
    bit         c1, c2, fb;
    int         dur, k;
    req = kv ? kd : mpend;
    mpend = req;
    old_dir = mdir;
    c1 = cm_seq[SETTLE];
    c2 = cm_seq[2*SETTLE];
    fb = 1'b0;
    if (c1) begin
      mdir = req; model_move(0, req); model_move(1, req); mmov = 1'b1; dur = SETTLE;
    end else if (req == mdir) begin
      mmov = 1'b0; dur = SETTLE;
    end else begin
      fb = 1'b1; dur = 2 * SETTLE;
      if (c2) begin model_move(0, mdir); model_move(1, mdir); mmov = 1'b1; end
      else mmov = 1'b0;
    end
    tick = 1'b1; key_valid = kv; key_dir = kd; can_move = cm_seq[0];
    @(posedge clk); #1;
    tick = 1'b0; key_valid = 1'b0; can_move = cm_seq[1];
    chk("probe_req", int'(probe_a), int'(req));
    chk("busy_e0", int'(busy_a), 1);
    k = 0;
    while (busy_a && k < 2 * SETTLE + 4) begin
      if (noise) begin
        tick = 1'($urandom);
        key_valid = 1'($urandom);
        key_dir = 2'($urandom);
        if (key_valid) mpend = key_dir;
      end
      if (k + 1 == tick_at) tick = 1'b1;
      @(posedge clk); #1;
      k++;
      tick = 1'b0; key_valid = 1'b0;
      if (k + 1 <= 2 * SETTLE) can_move = cm_seq[k + 1];
      else                     can_move = 1'($urandom);
      if (fb && k == SETTLE) chk("probe_fallback", int'(probe_a), int'(old_dir));
    end
    chk("busy_cycles", k, dur);
    chk("busy_b", int'(busy_b), 0);
    chk_model("txn");
  endtask

  initial begin
    // Table: scenarios from reset, run in order (state carries over)
    tbl[0] = '{1'b1, 2'd0, 1'b0, 1'b1, -1, 302, 352, 2'd2, 1'b1, XL, 447};
    tbl[1] = '{1'b0, 2'd0, 1'b1, 1'b0, -1, 302, 350, 2'd0, 1'b1, XL, 445};
    tbl[2] = '{1'b1, 2'd3, 1'b1, 1'b0, -1, 304, 350, 2'd3, 1'b1, XR, 445};
    tbl[3] = '{1'b1, 2'd1, 1'b0, 1'b0,  2, 304, 350, 2'd3, 1'b0, XR, 445};
    tbl[4] = '{1'b1, 2'd3, 1'b0, 1'b1,  3, 304, 350, 2'd3, 1'b0, XR, 445};
    tbl[5] = '{1'b1, 2'd1, 1'b1, 1'b0, -1, 304, 352, 2'd1, 1'b1, XR, 447};
    tbl[6] = '{1'b0, 2'd0, 1'b1, 1'b0, -1, 304, 354, 2'd1, 1'b1, XR, 448};
    tbl[7] = '{1'b0, 2'd0, 1'b1, 1'b0, -1, 304, 356, 2'd1, 1'b1, XR, 448};

    rst = 1'b0; tick = 1'b0; key_valid = 1'b0; key_dir = 2'd0; can_move = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_x", int'(x_a), 304);
    chk("rst_y", int'(y_a), 352);
    chk("rst_dir", int'(dir_a), 2);
    chk("rst_probe", int'(probe_a), 2);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_mov", int'(mov_a), 0);
    chk("rst_xb", int'(x_b), 1);
    chk("rst_yb", int'(y_b), 447);

    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k <= 2 * SETTLE; k++) cm_seq[k] = (k <= SETTLE) ? tbl[i].c1 : tbl[i].c2;
      txn(tbl[i].kv, tbl[i].kd, 1'b0, tbl[i].tick_at);
      chk($sformatf("tbl%0d_xa", i), int'(x_a), tbl[i].ax);
      chk($sformatf("tbl%0d_ya", i), int'(y_a), tbl[i].ay);
      chk($sformatf("tbl%0d_dir", i), int'(dir_a), int'(tbl[i].adir));
      chk($sformatf("tbl%0d_mov", i), int'(mov_a), int'(tbl[i].amov));
      chk($sformatf("tbl%0d_xb", i), int'(x_b), tbl[i].bx);
      chk($sformatf("tbl%0d_yb", i), int'(y_b), tbl[i].by);
    end

    // Reset asserted two cycles into the fallback probe
    tick = 1'b1; key_valid = 1'b1; key_dir = mdir ^ 2'b01; can_move = 1'b0;
    @(posedge clk); #1;
    tick = 1'b0; key_valid = 1'b0;
    repeat (SETTLE + 2) @(posedge clk);
    #1;
    chk("mid_busy", int'(busy_a), 1);
    rst = 1'b0;
    #1;
    chk("arst_x", int'(x_a), 304);
    chk("arst_y", int'(y_a), 352);
    chk("arst_dir", int'(dir_a), 2);
    chk("arst_probe", int'(probe_a), 2);
    chk("arst_busy", int'(busy_a), 0);
    chk("arst_mov", int'(mov_a), 0);
    chk("arst_xb", int'(x_b), 1);
    #2 rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    for (int k = 0; k <= 2 * SETTLE; k++) cm_seq[k] = 1'b1;
    txn(1'b1, 2'd3, 1'b0, -1);
    chk("post_rst_x", int'(x_a), 306);
    chk("post_rst_dir", int'(dir_a), 3);

    // Randomized transactions with noise ticks/keys during evaluation
    for (int n = 0; n < 80; n++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        key_valid = 1'($urandom);
        key_dir = 2'($urandom);
        if (key_valid) mpend = key_dir;
        @(posedge clk); #1;
        key_valid = 1'b0;
      end
      for (int k = 0; k <= 2 * SETTLE; k++) cm_seq[k] = ($urandom_range(0, 3) != 0);
      txn(1'($urandom), 2'($urandom), 1'b1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
